// File: rtl/sudoku_game_fsm.sv
// Top-level game controller for the N x N Sudoku core: menu, puzzle load handshake,
// cursor and number entry, pause, and win/lose tracking over the live board/vis registers.
module sudoku_game_fsm #(
    parameter int BOX         = 3,
    parameter int LEVELS      = 4,
    parameter int MAX_STRIKES = 3,
    parameter int TIME_W      = 11,
    parameter int TIME_LIMIT  = 0,
    localparam int N      = BOX * BOX,
    localparam int IDX_W  = $clog2(N),
    localparam int CELL_W = $clog2(N + 1),
    localparam int LVL_W  = (LEVELS > 1) ? $clog2(LEVELS) : 1,
    localparam int STR_W  = $clog2(MAX_STRIKES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  btn_up,
    input  logic                  btn_down,
    input  logic                  btn_left,
    input  logic                  btn_right,
    input  logic                  btn_start,
    input  logic                  btn_a,
    input  logic                  btn_b,
    input  logic                  tick,
    input  logic                  load_ack,
    input  logic [N*N*CELL_W-1:0] load_map,
    input  logic [N*N-1:0]        load_vis,
    output logic [2:0]            state,
    output logic [IDX_W-1:0]      pos_row,
    output logic [IDX_W-1:0]      pos_col,
    output logic [CELL_W-1:0]     sel_num,
    output logic [LVL_W-1:0]      level,
    output logic [STR_W-1:0]      strikes,
    output logic [TIME_W-1:0]     elapsed,
    output logic [N*N*CELL_W-1:0] board,
    output logic [N*N-1:0]        vis,
    output logic                  error,
    output logic                  load_req,
    output logic                  playing
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SELECT   = 3'd1,
        S_LOAD     = 3'd2,
        S_NAVIGATE = 3'd3,
        S_PICK     = 3'd4,
        S_PAUSE    = 3'd5,
        S_WIN      = 3'd6,
        S_LOSE     = 3'd7
    } state_t;

    localparam int KW = $clog2(N * N);
    localparam logic [IDX_W-1:0]  ROW_MAX = IDX_W'(N - 1);
    localparam logic [CELL_W-1:0] SEL_MAX = CELL_W'(N);
    localparam logic [LVL_W-1:0]  LVL_MAX = LVL_W'(LEVELS - 1);
    localparam logic [STR_W-1:0]  STR_MAX = STR_W'(MAX_STRIKES);
    localparam logic [TIME_W-1:0] LIMIT_V = TIME_W'(TIME_LIMIT);

    state_t            state_q;
    logic [KW-1:0]     cur_idx;
    logic [CELL_W-1:0] cur_sol;
    logic              cur_vis;
    logic              lose_now;
    logic              win_now;
    logic              pause_entry;
    logic              count_tick;

    assign state    = state_q;
    assign load_req = (state_q == S_LOAD);
    assign playing  = (state_q == S_NAVIGATE) || (state_q == S_PICK);

    assign cur_idx = KW'(pos_row) * KW'(N) + KW'(pos_col);
    assign cur_sol = board[cur_idx*CELL_W +: CELL_W];
    assign cur_vis = vis[cur_idx];

    // End-of-game checks look only at registered values, so they land one edge after the cause.
    assign lose_now = (strikes == STR_MAX) || ((TIME_LIMIT != 0) && (elapsed >= LIMIT_V));
    assign win_now  = &vis;

    // A tick on the edge that enters PAUSE is dropped; one on the edge that leaves PAUSE counts.
    assign pause_entry = (state_q == S_NAVIGATE) && btn_start && !btn_a && !lose_now && !win_now;
    assign count_tick  = tick && ((playing && !pause_entry) || ((state_q == S_PAUSE) && btn_start));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pos_row <= '0;
            pos_col <= '0;
            sel_num <= CELL_W'(1);
            level   <= '0;
            strikes <= '0;
            elapsed <= '0;
            board   <= '0;
            vis     <= '0;
            error   <= 1'b0;
        end else begin
            error <= 1'b0;
            if (count_tick && (elapsed != '1)) begin
                elapsed <= elapsed + 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (btn_start) state_q <= S_SELECT;
                end
                S_SELECT: begin
                    if (btn_a) begin
                        state_q <= S_LOAD;
                    end else if (btn_up) begin
                        if (level != LVL_MAX) level <= level + 1'b1;
                    end else if (btn_down) begin
                        if (level != '0) level <= level - 1'b1;
                    end
                end
                S_LOAD: begin
                    if (load_ack) begin
                        board   <= load_map;
                        vis     <= load_vis;
                        strikes <= '0;
                        elapsed <= '0;
                        pos_row <= '0;
                        pos_col <= '0;
                        sel_num <= CELL_W'(1);
                        state_q <= S_NAVIGATE;
                    end
                end
                S_NAVIGATE: begin
                    // btn_a freezes the cursor even when it lands on a clue and does nothing.
                    if (btn_a) begin
                        if (!cur_vis) begin
                            sel_num <= CELL_W'(1);
                            state_q <= S_PICK;
                        end
                    end else begin
                        if (btn_up)
                            pos_row <= (pos_row == '0) ? ROW_MAX : pos_row - 1'b1;
                        else if (btn_down)
                            pos_row <= (pos_row == ROW_MAX) ? '0 : pos_row + 1'b1;
                        if (btn_left)
                            pos_col <= (pos_col == '0) ? ROW_MAX : pos_col - 1'b1;
                        else if (btn_right)
                            pos_col <= (pos_col == ROW_MAX) ? '0 : pos_col + 1'b1;
                        if (btn_start) state_q <= S_PAUSE;
                    end
                end
                S_PICK: begin
                    if (btn_a) begin
                        if (sel_num == cur_sol) begin
                            vis[cur_idx] <= 1'b1;
                            state_q      <= S_NAVIGATE;
                        end else begin
                            if (strikes != STR_MAX) strikes <= strikes + 1'b1;
                            error <= 1'b1;
                        end
                    end else if (btn_b) begin
                        state_q <= S_NAVIGATE;
                    end else if (btn_up) begin
                        sel_num <= (sel_num == SEL_MAX) ? CELL_W'(1) : sel_num + 1'b1;
                    end else if (btn_down) begin
                        sel_num <= (sel_num <= CELL_W'(1)) ? SEL_MAX : sel_num - 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (btn_start) state_q <= S_NAVIGATE;
                end
                S_WIN, S_LOSE: begin
                    if (btn_start) state_q <= S_SELECT;
                end
                default: state_q <= S_IDLE;
            endcase

            if (playing) begin
                if (lose_now)
                    state_q <= S_LOSE;
                else if (win_now)
                    state_q <= S_WIN;
            end
        end
    end

endmodule

// File: tb/tb_sudoku_game_fsm.sv
// Directed bench for sudoku_game_fsm: load, navigation wrap, entry, strikes, time limit, reset.
module tb_sudoku_game_fsm;

    localparam int N      = 9;
    localparam int IDX_W  = 4;
    localparam int CELL_W = 4;
    localparam int LVL_W  = 2;
    localparam int STR_W  = 2;
    localparam int TIME_W = 11;

    localparam logic [6:0] B_UP    = 7'b1000000;
    localparam logic [6:0] B_DOWN  = 7'b0100000;
    localparam logic [6:0] B_LEFT  = 7'b0010000;
    localparam logic [6:0] B_RIGHT = 7'b0001000;
    localparam logic [6:0] B_START = 7'b0000100;
    localparam logic [6:0] B_A     = 7'b0000010;
    localparam logic [6:0] B_B     = 7'b0000001;
    localparam logic [6:0] B_NONE  = 7'b0000000;

    logic                  clk;
    logic                  reset;
    logic                  btn_up, btn_down, btn_left, btn_right, btn_start, btn_a, btn_b;
    logic                  tick;
    logic                  load_ack;
    logic [N*N*CELL_W-1:0] load_map;
    logic [N*N-1:0]        load_vis;
    logic [2:0]            state;
    logic [IDX_W-1:0]      pos_row, pos_col;
    logic [CELL_W-1:0]     sel_num;
    logic [LVL_W-1:0]      level;
    logic [STR_W-1:0]      strikes;
    logic [TIME_W-1:0]     elapsed;
    logic [N*N*CELL_W-1:0] board;
    logic [N*N-1:0]        vis;
    logic                  error;
    logic                  load_req;
    logic                  playing;

    int checks = 0;
    int errors = 0;

    logic [N*N-1:0] vis_a;
    logic [N*N-1:0] vis_b;
    logic [N*N-1:0] all_vis;

    sudoku_game_fsm #(
        .BOX(3), .LEVELS(4), .MAX_STRIKES(3), .TIME_W(TIME_W), .TIME_LIMIT(10)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_start(btn_start), .btn_a(btn_a), .btn_b(btn_b),
        .tick(tick), .load_ack(load_ack), .load_map(load_map), .load_vis(load_vis),
        .state(state), .pos_row(pos_row), .pos_col(pos_col), .sel_num(sel_num),
        .level(level), .strikes(strikes), .elapsed(elapsed), .board(board), .vis(vis),
        .error(error), .load_req(load_req), .playing(playing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Classic shifted-row pattern: a valid solved grid with values 1..9.
    function automatic logic [N*N*CELL_W-1:0] make_map();
        logic [N*N*CELL_W-1:0] m;
        m = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                m[(r*N + c)*CELL_W +: CELL_W] = CELL_W'(((r*3 + r/3 + c) % 9) + 1);
        return m;
    endfunction

    task automatic applyStimulus(input logic [6:0] btns, input logic t, input logic ack);
        {btn_up, btn_down, btn_left, btn_right, btn_start, btn_a, btn_b} = btns;
        tick     = t;
        load_ack = ack;
        @(posedge clk);
        #1;
        {btn_up, btn_down, btn_left, btn_right, btn_start, btn_a, btn_b} = B_NONE;
        tick     = 1'b0;
        load_ack = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        {btn_up, btn_down, btn_left, btn_right, btn_start, btn_a, btn_b} = B_NONE;
        tick     = 1'b0;
        load_ack = 1'b0;
        load_map = make_map();
        all_vis  = '1;
        vis_a    = '1;
        vis_a[79] = 1'b0;
        vis_b    = '1;
        vis_b[4] = 1'b0;
        load_vis = vis_a;
        reset    = 1'b1;
        #12;
        checkOutput("reset_state", state, 0);
        checkOutput("reset_pos", {pos_row, pos_col}, 0);
        checkOutput("reset_sel", sel_num, 1);
        checkOutput("reset_level", level, 0);
        checkOutput("reset_vis", vis, 0);
        checkOutput("reset_board", board, 0);
        checkOutput("reset_error", error, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        $display("[TB] start, level select, load");
        applyStimulus(B_START, 0, 0);
        checkOutput("select_state", state, 1);
        for (int i = 0; i < 5; i++) applyStimulus(B_UP, 0, 0);
        checkOutput("level_saturate", level, 3);
        applyStimulus(B_DOWN, 0, 0);
        checkOutput("level_down", level, 2);
        applyStimulus(B_UP, 0, 0);
        applyStimulus(B_A | B_UP, 0, 0);
        checkOutput("load_state", state, 2);
        checkOutput("load_req", load_req, 1);
        checkOutput("level_a_priority", level, 3);
        applyStimulus(B_NONE, 0, 0);
        checkOutput("load_wait", state, 2);
        applyStimulus(B_NONE, 0, 1);
        checkOutput("nav_after_ack", state, 3);
        checkOutput("nav_pos", {pos_row, pos_col}, 0);
        checkOutput("board_loaded", board, make_map());
        checkOutput("vis_loaded", vis, vis_a);
        checkOutput("playing", playing, 1);
        checkOutput("load_req_off", load_req, 0);

        $display("[TB] cursor wrap and entry to win");
        applyStimulus(B_UP | B_LEFT, 0, 0);
        checkOutput("wrap_up_left", {pos_row, pos_col}, {4'd8, 4'd8});
        applyStimulus(B_RIGHT, 0, 0);
        checkOutput("wrap_right", {pos_row, pos_col}, {4'd8, 4'd0});
        applyStimulus(B_A | B_RIGHT, 0, 0);
        checkOutput("a_on_clue_pos", {pos_row, pos_col}, {4'd8, 4'd0});
        checkOutput("a_on_clue_state", state, 3);
        applyStimulus(B_LEFT, 0, 0);
        applyStimulus(B_LEFT, 0, 0);
        checkOutput("at_hidden", {pos_row, pos_col}, {4'd8, 4'd7});
        applyStimulus(B_A, 0, 0);
        checkOutput("pick_state", state, 4);
        checkOutput("pick_sel", sel_num, 1);
        applyStimulus(B_DOWN, 0, 0);
        checkOutput("sel_wrap_down", sel_num, 9);
        applyStimulus(B_UP, 0, 0);
        checkOutput("sel_wrap_up", sel_num, 1);
        for (int i = 0; i < 6; i++) applyStimulus(B_UP, 0, 0);
        checkOutput("sel_seven", sel_num, 7);
        applyStimulus(B_A, 0, 0);
        checkOutput("correct_state", state, 3);
        checkOutput("correct_vis", vis, all_vis);
        checkOutput("correct_no_error", error, 0);
        applyStimulus(B_NONE, 0, 0);
        checkOutput("win_state", state, 6);
        applyStimulus(B_START, 0, 0);
        checkOutput("win_to_select", state, 1);
        checkOutput("level_retained", level, 3);

        $display("[TB] strikes to lose");
        load_vis = vis_b;
        applyStimulus(B_A, 0, 0);
        applyStimulus(B_NONE, 0, 1);
        checkOutput("reload_strikes", strikes, 0);
        for (int i = 0; i < 4; i++) applyStimulus(B_RIGHT, 0, 0);
        checkOutput("at_cell4", {pos_row, pos_col}, {4'd0, 4'd4});
        applyStimulus(B_A, 0, 0);
        applyStimulus(B_B, 0, 0);
        checkOutput("b_back_state", state, 3);
        checkOutput("b_vis_kept", vis, vis_b);
        applyStimulus(B_A, 0, 0);
        applyStimulus(B_START, 0, 0);
        checkOutput("pick_ignores_start", state, 4);
        applyStimulus(B_UP, 0, 0);
        checkOutput("sel_two", sel_num, 2);
        applyStimulus(B_A, 0, 0);
        checkOutput("wrong1_error", error, 1);
        checkOutput("wrong1_strikes", strikes, 1);
        checkOutput("wrong1_state", state, 4);
        applyStimulus(B_NONE, 0, 0);
        checkOutput("error_one_cycle", error, 0);
        applyStimulus(B_A, 0, 0);
        checkOutput("wrong2_strikes", strikes, 2);
        applyStimulus(B_A, 0, 0);
        checkOutput("wrong3_error", error, 1);
        checkOutput("wrong3_strikes", strikes, 3);
        checkOutput("wrong3_state", state, 4);
        applyStimulus(B_NONE, 0, 0);
        checkOutput("lose_state", state, 7);
        checkOutput("lose_strikes_held", strikes, 3);

        $display("[TB] time limit with pause");
        applyStimulus(B_START, 0, 0);
        applyStimulus(B_A, 0, 0);
        applyStimulus(B_NONE, 0, 1);
        checkOutput("time_start", elapsed, 0);
        for (int i = 0; i < 5; i++) applyStimulus(B_NONE, 1, 0);
        checkOutput("five_ticks", elapsed, 5);
        applyStimulus(B_START, 1, 0);
        checkOutput("pause_state", state, 5);
        checkOutput("pause_entry_tick", elapsed, 5);
        for (int i = 0; i < 4; i++) applyStimulus(B_NONE, 1, 0);
        checkOutput("paused_frozen", elapsed, 5);
        applyStimulus(B_START, 1, 0);
        checkOutput("resume_state", state, 3);
        checkOutput("resume_tick", elapsed, 6);
        for (int i = 0; i < 4; i++) applyStimulus(B_NONE, 1, 0);
        checkOutput("elapsed_ten", elapsed, 10);
        checkOutput("still_nav", state, 3);
        applyStimulus(B_NONE, 0, 0);
        checkOutput("time_lose", state, 7);

        $display("[TB] async reset in PICK");
        applyStimulus(B_START, 0, 0);
        applyStimulus(B_A, 0, 0);
        applyStimulus(B_NONE, 0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(B_RIGHT, 0, 0);
        applyStimulus(B_A, 0, 0);
        applyStimulus(B_UP, 0, 0);
        applyStimulus(B_A, 0, 0);
        checkOutput("pre_reset_state", state, 4);
        checkOutput("pre_reset_strikes", strikes, 1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_state", state, 0);
        checkOutput("async_pos", {pos_row, pos_col}, 0);
        checkOutput("async_vis", vis, 0);
        checkOutput("async_strikes", strikes, 0);
        checkOutput("async_level", level, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
